// File: rtl/axil2sreg_bridge_if.sv
// AXI4-Lite slave-side channel bundle used between the PS port and the register-bus bridge.
interface axil2sreg_bridge_if;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axil2sreg_bridge.sv
// AXI4-Lite slave that serialises CPU accesses into single-word strobes on the simple
// en/wen/addr/din/dout register bus, one transaction in flight at a time.
module axil2sreg_bridge #(
    parameter int AW     = 18,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    axil2sreg_bridge_if.slave     axi,
    output logic                  reg_en,
    output logic                  reg_wen,
    output logic [AW-1:0]         reg_addr,
    output logic [31:0]           reg_din,
    input  logic [31:0]           reg_dout
);

    typedef enum logic [2:0] {
        IDLE,
        WR_STB,
        WR_RESP,
        RD_STB,
        RD_RESP
    } state_t;

    localparam logic       PRIO_WRITE = 1'b0;
    localparam logic       PRIO_READ  = 1'b1;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SLV   = 2'b10;
    localparam logic [1:0] RD_LAST    = 2'(RD_LAT - 1);

    state_t        state;
    logic          aw_held;
    logic          w_held;
    logic          prio;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    logic [1:0]    rd_cnt;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic wr_full;
    logic aw_next;
    logic w_next;

    assign aw_hs   = axi.s_awvalid & axi.s_awready;
    assign w_hs    = axi.s_wvalid & axi.s_wready;
    assign ar_hs   = axi.s_arvalid & axi.s_arready;
    assign wr_full = aw_held & w_held;
    assign aw_next = aw_held | aw_hs;
    assign w_next  = w_held | w_hs;

    // Upper address bits belong to the register blocks' decode; byte-lane bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi.s_awaddr[31:AW], axi.s_awaddr[1:0],
                                axi.s_araddr[31:AW], axi.s_araddr[1:0]};

    // Ready flags are registered one step ahead from the next-state holding flags, so they
    // are low during reset and only rise on the first clock after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            prio          <= PRIO_WRITE;
            wr_addr       <= '0;
            wr_data       <= '0;
            wr_strb       <= '0;
            rd_cnt        <= '0;
            reg_en        <= 1'b0;
            reg_wen       <= 1'b0;
            reg_addr      <= '0;
            reg_din       <= '0;
            axi.s_awready <= 1'b0;
            axi.s_wready  <= 1'b0;
            axi.s_arready <= 1'b0;
            axi.s_bvalid  <= 1'b0;
            axi.s_bresp   <= RESP_OKAY;
            axi.s_rvalid  <= 1'b0;
            axi.s_rresp   <= RESP_OKAY;
            axi.s_rdata   <= '0;
        end else begin
            reg_en  <= 1'b0;
            reg_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        aw_held <= 1'b1;
                        wr_addr <= {axi.s_awaddr[AW-1:2], 2'b00};
                    end
                    if (w_hs) begin
                        w_held  <= 1'b1;
                        wr_data <= axi.s_wdata;
                        wr_strb <= axi.s_wstrb;
                    end
                    // A read only gets through a complete write when prio says so.
                    if (ar_hs) begin
                        state         <= RD_STB;
                        reg_en        <= 1'b1;
                        reg_addr      <= {axi.s_araddr[AW-1:2], 2'b00};
                        rd_cnt        <= RD_LAST;
                        if (wr_full) begin
                            prio <= PRIO_WRITE;
                        end
                        axi.s_awready <= 1'b0;
                        axi.s_wready  <= 1'b0;
                        axi.s_arready <= 1'b0;
                    end else if (wr_full) begin
                        state <= WR_STB;
                        if (wr_strb == 4'hF) begin
                            reg_en   <= 1'b1;
                            reg_wen  <= 1'b1;
                            reg_addr <= wr_addr;
                            reg_din  <= wr_data;
                        end
                        if (axi.s_arvalid) begin
                            prio <= PRIO_READ;
                        end
                        axi.s_awready <= 1'b0;
                        axi.s_wready  <= 1'b0;
                        axi.s_arready <= 1'b0;
                    end else begin
                        axi.s_awready <= !aw_next;
                        axi.s_wready  <= !w_next;
                        axi.s_arready <= !(aw_next && w_next && (prio == PRIO_WRITE));
                    end
                end
                WR_STB: begin
                    state        <= WR_RESP;
                    aw_held      <= 1'b0;
                    w_held       <= 1'b0;
                    axi.s_bvalid <= 1'b1;
                    axi.s_bresp  <= (wr_strb == 4'hF) ? RESP_OKAY : RESP_SLV;
                end
                WR_RESP: begin
                    if (axi.s_bready) begin
                        state         <= IDLE;
                        axi.s_bvalid  <= 1'b0;
                        axi.s_awready <= 1'b1;
                        axi.s_wready  <= 1'b1;
                        axi.s_arready <= 1'b1;
                    end
                end
                RD_STB: begin
                    if (rd_cnt == 2'd0) begin
                        state        <= RD_RESP;
                        axi.s_rdata  <= reg_dout;
                        axi.s_rresp  <= RESP_OKAY;
                        axi.s_rvalid <= 1'b1;
                    end else begin
                        rd_cnt <= rd_cnt - 2'd1;
                        reg_en <= 1'b1;
                    end
                end
                RD_RESP: begin
                    // A write may have been parked while this read won the contest.
                    if (axi.s_rready) begin
                        state         <= IDLE;
                        axi.s_rvalid  <= 1'b0;
                        axi.s_awready <= !aw_held;
                        axi.s_wready  <= !w_held;
                        axi.s_arready <= !(wr_full && (prio == PRIO_WRITE));
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
